sipo_1to10_align: RTL and testbench
===================================

Name: sipo_1to10_align

Overview:
- TMDS receive-side deserializer: the inverse of the 10:1 transmit serializer.
- Takes one serial TMDS bit per clock, assembles 10-bit parallel words with bit 0 received first, and emits one word every 10 clocks.
- Finds the 10-bit word boundary by bit-slipping until DVI control tokens appear repeatedly at the boundary, then reports lock.
- Sits per channel between the serial input path and the TMDS decoder, all in the bit-clock domain.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens at the word boundary required to declare lock.
- MISS_WORDS, 4095: words without any control token before a bit-slip (while searching) or loss of lock (while locked). Must exceed the longest active-video run. Maximum 4095 (12-bit counter).

Ports:
- SI_clk, input, 1: bit clock. One serial bit is sampled per rising edge.
- reset, input, 1: asynchronous, active-high reset.
- SI_data, input, 1: serial TMDS bit, sampled on every SI_clk edge.
- PO_data, output, 10: aligned parallel word. PO_data[0] is the earliest-received bit.
- PO_valid, output, 1: one-cycle strobe; PO_data is new this cycle.
- PO_ctrl, output, 1: PO_data is a control token; qualified by PO_valid.
- locked, output, 1: word alignment achieved.
- slip, output, 1: one-cycle pulse when the word boundary is moved by one bit.

Behaviour:
- Reset (asynchronous):
  - shift register, bit_cnt, miss_cnt and tok_cnt clear to 0;
  - state returns to SEARCH;
  - PO_data=10'h000; PO_valid=0, PO_ctrl=0, locked=0, slip=0.
- Shift register: every edge, sr <= {SI_data, sr[9:1]}.
- bit_cnt counts 0..9. word_end = (bit_cnt==9) and no slip hold is active.
- On word_end, at the next edge:
  - PO_data <= {SI_data, sr[9:1]};
  - PO_valid <= 1;
  - PO_ctrl <= (word is one of 10'h354, 10'h0AB, 10'h154, 10'h2AB).
- Latency: the last bit of a word is on SI_data in cycle N; PO_valid=1 with that word in cycle N+1.
- PO_valid is otherwise 0. PO_data holds its value between strobes.
- Bit-slip:
  - When a slip is requested, bit_cnt holds at 0 for one extra cycle.
  - That one word period is 11 clocks; the boundary moves one bit later.
  - slip pulses high for exactly one cycle, in the same cycle PO_valid would otherwise signal the decision word.
  - Ten slips return the boundary to its original alignment; the search wraps modulo 10.
- Alignment FSM. It evaluates once per word, at word_end, on the word being captured. "tok" means that word is a control token.
  - SEARCH, tok: tok_cnt=1, miss_cnt=0, go to VERIFY.
  - SEARCH, not tok: miss_cnt++. When miss_cnt reaches MISS_WORDS, request a slip and clear miss_cnt.
  - VERIFY, tok: tok_cnt++. When tok_cnt reaches LOCK_COUNT, go to LOCKED and set locked=1.
  - VERIFY, not tok: go to SEARCH, clear tok_cnt. No slip.
  - LOCKED, tok: miss_cnt=0.
  - LOCKED, not tok: miss_cnt++. When miss_cnt reaches MISS_WORDS, go to SEARCH, set locked=0 and request a slip.
- locked is registered and changes on the edge following the deciding word_end. It is asserted in the same cycle as PO_valid for the LOCK_COUNT-th token.
- Only one slip can be pending at a time. A slip request during a hold cycle cannot occur, because word_end is suppressed during the hold.
- Asserting reset mid-word discards the partial word. The first word after reset release completes at the 10th edge after release.

Test Plan:
- Aligned stream: send 20 copies of 10'h354, LSB first, starting at the first edge after reset release. Required response:
  - PO_valid every 10 cycles, PO_data=10'h354, PO_ctrl=1;
  - locked rises with the 8th word;
  - slip never pulses.
- Offset by 3 bits: send 3 junk bits, then repeated 10'h0AB, with MISS_WORDS=4 for the bench. Required response:
  - slip pulses exactly 3 times (each pulse after 4 missed words);
  - then 8 consecutive 10'h0AB words and locked=1.
- Broken verify: send 5 × 10'h154, then 1 × 10'h1F0 data word, then 8 × 10'h154 (aligned). Required response:
  - no lock after the first 5 tokens;
  - state returns to SEARCH with no slip;
  - locked rises on the 8th token of the second run.
- Loss of lock: while locked with MISS_WORDS=16, send 16 non-token words. Required response: locked falls and slip pulses once, both with the 16th word.
- Reset mid-word: assert reset 4 bits into a word. Required response:
  - all outputs go to 0 immediately (asynchronously);
  - after release, the first PO_valid occurs on the 11th cycle after release and carries the 10 bits received after release.
- Token decode: send each of 10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h155 aligned. Required response: PO_ctrl=1 for the first four and PO_ctrl=0 for 10'h155.

Source files
------------

// File: rtl/sipo_1to10_align.sv
// TMDS receive deserializer: assembles 10-bit words LSB-first from the serial stream
// and bit-slips the word boundary until DVI control tokens repeatedly land on it.
module sipo_1to10_align #(
  parameter int LOCK_COUNT = 8,
  parameter int MISS_WORDS = 4095
) (
  input  logic       SI_clk,
  input  logic       reset,
  input  logic       SI_data,
  output logic [9:0] PO_data,
  output logic       PO_valid,
  output logic       PO_ctrl,
  output logic       locked,
  output logic       slip
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int               TOK_W    = $clog2(LOCK_COUNT + 1);
  localparam logic [TOK_W-1:0] TOK_LIM  = TOK_W'(LOCK_COUNT);
  localparam logic [11:0]      MISS_LIM = 12'(MISS_WORDS);

  // The oldest bit of the 10-bit window is never reused once shifted out, so only
  // the nine most recent bits are stored; the tenth comes straight from SI_data.
  logic [8:0]       sr_q, sr_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic             hold_q, hold_d;
  logic [11:0]      miss_cnt_q, miss_cnt_d;
  logic [TOK_W-1:0] tok_cnt_q, tok_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [9:0]       po_data_q, po_data_d;
  logic             po_valid_q, po_valid_d;
  logic             po_ctrl_q, po_ctrl_d;
  logic             locked_q, locked_d;
  logic             slip_q, slip_d;

  logic [9:0]       word;
  logic             word_end;
  logic             is_tok;
  logic             slip_req;
  logic [11:0]      miss_inc;
  logic [TOK_W-1:0] tok_inc;

  always_comb begin
    word     = {SI_data, sr_q};
    word_end = (bit_cnt_q == 4'd9) && !hold_q;
    is_tok   = (word == 10'h354) || (word == 10'h0AB) ||
               (word == 10'h154) || (word == 10'h2AB);
    miss_inc = miss_cnt_q + 12'd1;
    tok_inc  = tok_cnt_q + 1'b1;

    sr_d       = word[9:1];
    miss_cnt_d = miss_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    state_d    = state_q;
    locked_d   = locked_q;
    slip_req   = 1'b0;

    if (word_end) begin
      case (state_q)
        ST_SEARCH: begin
          if (is_tok) begin
            tok_cnt_d  = TOK_W'(1);
            miss_cnt_d = '0;
            if (TOK_LIM <= TOK_W'(1)) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = ST_VERIFY;
            end
          end else if (miss_inc >= MISS_LIM) begin
            miss_cnt_d = '0;
            slip_req   = 1'b1;
          end else begin
            miss_cnt_d = miss_inc;
          end
        end
        ST_VERIFY: begin
          if (is_tok) begin
            tok_cnt_d = tok_inc;
            if (tok_inc >= TOK_LIM) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            tok_cnt_d = '0;
            state_d   = ST_SEARCH;
          end
        end
        ST_LOCKED: begin
          if (is_tok) begin
            miss_cnt_d = '0;
          end else if (miss_inc >= MISS_LIM) begin
            miss_cnt_d = '0;
            tok_cnt_d  = '0;
            state_d    = ST_SEARCH;
            locked_d   = 1'b0;
            slip_req   = 1'b1;
          end else begin
            miss_cnt_d = miss_inc;
          end
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end

    // A slip stretches the next word period to 11 clocks by holding the count at 0.
    hold_d = 1'b0;
    if (hold_q) begin
      bit_cnt_d = 4'd0;
    end else if (word_end) begin
      bit_cnt_d = 4'd0;
      hold_d    = slip_req;
    end else begin
      bit_cnt_d = bit_cnt_q + 4'd1;
    end

    po_valid_d = word_end;
    po_data_d  = word_end ? word : po_data_q;
    po_ctrl_d  = word_end ? is_tok : po_ctrl_q;
    slip_d     = slip_req;
  end

  always_ff @(posedge SI_clk or posedge reset) begin
    if (reset) begin
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      hold_q     <= 1'b0;
      miss_cnt_q <= '0;
      tok_cnt_q  <= '0;
      state_q    <= ST_SEARCH;
      po_data_q  <= '0;
      po_valid_q <= 1'b0;
      po_ctrl_q  <= 1'b0;
      locked_q   <= 1'b0;
      slip_q     <= 1'b0;
    end else begin
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      hold_q     <= hold_d;
      miss_cnt_q <= miss_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      state_q    <= state_d;
      po_data_q  <= po_data_d;
      po_valid_q <= po_valid_d;
      po_ctrl_q  <= po_ctrl_d;
      locked_q   <= locked_d;
      slip_q     <= slip_d;
    end
  end

  assign PO_data  = po_data_q;
  assign PO_valid = po_valid_q;
  assign PO_ctrl  = po_ctrl_q;
  assign locked   = locked_q;
  assign slip     = slip_q;

endmodule

// File: tb/tb_sipo_1to10_align.sv
// Bench for sipo_1to10_align: two instances (short and long miss limits) share one serial
// stream and are compared every cycle against a bit-history model of word framing and alignment.
module tb_sipo_1to10_align;

  localparam int LOCK_N = 8;
  localparam int MISS_A = 4;
  localparam int MISS_B = 16;
  localparam logic [9:0] DECODE_WORDS [5] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB, 10'h155};
  localparam logic       DECODE_CTRL  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  logic       SI_clk;
  logic       reset;
  logic       SI_data;
  logic [9:0] aData, bData;
  logic       aValid, bValid, aCtrl, bCtrl, aLocked, bLocked, aSlip, bSlip;

  sipo_1to10_align #(.LOCK_COUNT(LOCK_N), .MISS_WORDS(MISS_A)) dutA (
    .SI_clk(SI_clk), .reset(reset), .SI_data(SI_data),
    .PO_data(aData), .PO_valid(aValid), .PO_ctrl(aCtrl), .locked(aLocked), .slip(aSlip)
  );

  sipo_1to10_align #(.LOCK_COUNT(LOCK_N), .MISS_WORDS(MISS_B)) dutB (
    .SI_clk(SI_clk), .reset(reset), .SI_data(SI_data),
    .PO_data(bData), .PO_valid(bValid), .PO_ctrl(bCtrl), .locked(bLocked), .slip(bSlip)
  );

  initial SI_clk = 1'b0;
  always #5 SI_clk = ~SI_clk;

  int nCmp;
  int nFail;

  // Reference model: every received bit since reset plus, per instance, the bit index
  // where the current word ends and the token/miss bookkeeping of the alignment rules.
  bit         hist[$];
  int         mEnd[2];
  int         mMiss[2];
  int         mRun[2];
  int         missLim[2];
  logic       mLock[2];
  logic [9:0] expData[2];
  logic       expValid[2];
  logic       expCtrl[2];
  logic       expSlip[2];

  int slipA, slipB, validA, validB;

  function automatic logic isToken(input logic [9:0] w);
    logic [9:0] toks [4];
    toks = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    isToken = 1'b0;
    for (int t = 0; t < 4; t++)
      if (w == toks[t]) isToken = 1'b1;
  endfunction

  task automatic modelReset();
    hist.delete();
    missLim[0] = MISS_A;
    missLim[1] = MISS_B;
    for (int i = 0; i < 2; i++) begin
      mEnd[i]     = 9;
      mMiss[i]    = 0;
      mRun[i]     = 0;
      mLock[i]    = 1'b0;
      expData[i]  = 10'h000;
      expValid[i] = 1'b0;
      expCtrl[i]  = 1'b0;
      expSlip[i]  = 1'b0;
    end
    slipA = 0; slipB = 0; validA = 0; validB = 0;
  endtask

  task automatic modelEdge(input logic b);
    int         idx;
    logic [9:0] w;
    logic       tok;
    logic       doSlip;
    hist.push_back(b);
    idx = hist.size() - 1;
    for (int i = 0; i < 2; i++) begin
      expValid[i] = 1'b0;
      expSlip[i]  = 1'b0;
      if (idx == mEnd[i]) begin
        for (int k = 0; k < 10; k++) w[k] = hist[idx - 9 + k];
        tok    = isToken(w);
        doSlip = 1'b0;
        expValid[i] = 1'b1;
        expData[i]  = w;
        expCtrl[i]  = tok;
        if (mLock[i]) begin
          if (tok) mMiss[i] = 0;
          else begin
            mMiss[i]++;
            if (mMiss[i] == missLim[i]) begin
              mLock[i] = 1'b0; mMiss[i] = 0; mRun[i] = 0; doSlip = 1'b1;
            end
          end
        end else if (mRun[i] > 0) begin
          if (tok) begin
            mRun[i]++;
            if (mRun[i] == LOCK_N) mLock[i] = 1'b1;
          end else begin
            mRun[i] = 0;
          end
        end else begin
          if (tok) begin
            mRun[i] = 1; mMiss[i] = 0;
          end else begin
            mMiss[i]++;
            if (mMiss[i] == missLim[i]) begin
              mMiss[i] = 0; doSlip = 1'b1;
            end
          end
        end
        expSlip[i] = doSlip;
        mEnd[i] += doSlip ? 11 : 10;
      end
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [9:0] oData;
    logic       oValid, oCtrl, oLocked, oSlip;
    string      n;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin
        oData = aData; oValid = aValid; oCtrl = aCtrl; oLocked = aLocked; oSlip = aSlip; n = "A";
      end else begin
        oData = bData; oValid = bValid; oCtrl = bCtrl; oLocked = bLocked; oSlip = bSlip; n = "B";
      end
      checkVal({n, ".valid"},  32'(oValid),  32'(expValid[i]));
      checkVal({n, ".data"},   32'(oData),   32'(expData[i]));
      checkVal({n, ".locked"}, 32'(oLocked), 32'(mLock[i]));
      checkVal({n, ".slip"},   32'(oSlip),   32'(expSlip[i]));
      if (expValid[i]) checkVal({n, ".ctrl"}, 32'(oCtrl), 32'(expCtrl[i]));
    end
  endtask

  // Drive one bit for the next rising edge, then check the outputs that edge produced.
  task automatic applyStimulus(input logic b);
    SI_data = b;
    modelEdge(b);
    @(negedge SI_clk);
    checkOutput();
    if (aSlip === 1'b1)  slipA++;
    if (bSlip === 1'b1)  slipB++;
    if (aValid === 1'b1) validA++;
    if (bValid === 1'b1) validB++;
  endtask

  task automatic sendWord(input logic [9:0] w);
    for (int k = 0; k < 10; k++) applyStimulus(w[k]);
  endtask

  task automatic doReset();
    reset = 1'b1;
    modelReset();
    #1 checkOutput();
    @(negedge SI_clk);
    reset = 1'b0;
  endtask

  function automatic logic [9:0] randomData();
    logic [9:0] w;
    do w = 10'($urandom_range(0, 1023)); while (isToken(w));
    return w;
  endfunction

  initial begin
    logic [9:0] w;
    int         offs;
    nCmp    = 0;
    nFail   = 0;
    SI_data = 1'b0;
    reset   = 1'b1;
    modelReset();
    repeat (2) @(negedge SI_clk);
    checkOutput();
    reset = 1'b0;

    $display("[TB] aligned 10'h354 stream");
    for (int j = 0; j < 20; j++) begin
      sendWord(10'h354);
      if (j == 6) checkVal("aligned.noLockAt7", 32'(aLocked), 32'd0);
      if (j == 7) checkVal("aligned.lockAt8", 32'(aLocked), 32'd1);
    end
    checkVal("aligned.validCount", validA, 20);
    checkVal("aligned.noSlip", slipA, 0);
    checkVal("aligned.ctrl", 32'(aCtrl), 32'd1);

    $display("[TB] three-bit offset 10'h0AB stream");
    doReset();
    for (int k = 0; k < 3; k++) applyStimulus(1'($urandom_range(0, 1)));
    for (int j = 0; j < 22; j++) sendWord(10'h0AB);
    checkVal("offset.slipCount", slipA, 3);
    checkVal("offset.locked", 32'(aLocked), 32'd1);
    checkVal("offset.data", 32'(aData), 32'h0AB);

    $display("[TB] broken verify run");
    doReset();
    for (int j = 0; j < 5; j++) sendWord(10'h154);
    checkVal("broken.noEarlyLock", 32'(aLocked), 32'd0);
    sendWord(10'h1F0);
    for (int j = 0; j < 8; j++) begin
      sendWord(10'h154);
      if (j == 6) checkVal("broken.noLockAt7", 32'(aLocked), 32'd0);
    end
    checkVal("broken.lockAt8", 32'(aLocked), 32'd1);
    checkVal("broken.noSlip", slipA, 0);

    $display("[TB] loss of lock on long-limit instance");
    slipB = 0;
    for (int j = 0; j < 16; j++) begin
      sendWord(randomData());
      if (j == 14) checkVal("loss.stillLocked", 32'(bLocked), 32'd1);
    end
    checkVal("loss.lockedFalls", 32'(bLocked), 32'd0);
    checkVal("loss.slipWith16th", 32'(bSlip), 32'd1);
    checkVal("loss.slipCount", slipB, 1);

    $display("[TB] reset in the middle of a word");
    doReset();
    sendWord(10'h354);
    sendWord(10'h2AB);
    for (int k = 0; k < 4; k++) applyStimulus(1'($urandom_range(0, 1)));
    #2 reset = 1'b1;
    modelReset();
    #1 checkOutput();
    checkVal("midReset.dataZero", 32'(aData), 32'd0);
    @(negedge SI_clk);
    reset = 1'b0;
    w = 10'($urandom_range(0, 1023));
    for (int k = 0; k < 10; k++) applyStimulus(w[k]);
    checkVal("midReset.firstValidCycle11", validA, 1);
    checkVal("midReset.firstValidNow", 32'(aValid), 32'd1);
    checkVal("midReset.firstWord", 32'(aData), 32'(w));

    $display("[TB] token decode");
    doReset();
    for (int j = 0; j < 5; j++) begin
      w = DECODE_WORDS[j];
      sendWord(w);
      checkVal($sformatf("decode.ctrl_%03h", w), 32'(aCtrl), 32'(DECODE_CTRL[j]));
      checkVal($sformatf("decode.data_%03h", w), 32'(aData), 32'(w));
    end

    $display("[TB] random offset, mixed token/data stream");
    doReset();
    offs = $urandom_range(0, 9);
    for (int k = 0; k < offs; k++) applyStimulus(1'($urandom_range(0, 1)));
    for (int j = 0; j < 80; j++) begin
      if ($urandom_range(0, 3) != 0) begin
        w = DECODE_WORDS[$urandom_range(0, 3)];
      end else begin
        w = randomData();
      end
      sendWord(w);
    end

    @(negedge SI_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before end of stimulus");
    $fatal(1, "[TB] watchdog");
  end

endmodule
